// File: rtl/quad_decoder_if.sv
// Quadrature decoder pin/status bundle.
//   slave  : decoder side  (A, B, Clr in; Up, Down, Dir, Err, Err_Sticky,
//            Position, High, Low out)
//   master : driver/monitor side (mirror of slave)
interface quad_decoder_if #(
    parameter int WIDTH = 5
);
    logic             A;
    logic             B;
    logic             Clr;
    logic             Up;
    logic             Down;
    logic             Dir;
    logic             Err;
    logic             Err_Sticky;
    logic [WIDTH-1:0] Position;
    logic             High;
    logic             Low;

    modport slave (
        input  A, B, Clr,
        output Up, Down, Dir, Err, Err_Sticky, Position, High, Low
    );

    modport master (
        output A, B, Clr,
        input  Up, Down, Dir, Err, Err_Sticky, Position, High, Low
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder with 2-flop synchronizers, per-channel stability filter,
// Gray-code step decode and a saturating position counter.
//   CLK  : clock, rising edge
//   RST  : synchronous active-low reset
//   bus  : quad_decoder_if.slave (A/B pins, Clr in; step pulses, direction,
//          error pulse/sticky, Position and High/Low flags out)
module quad_decoder #(
    parameter int WIDTH = 5,
    parameter int FILT  = 2   // 1..7 stable samples before a change is accepted
) (
    input  logic           CLK,
    input  logic           RST,
    quad_decoder_if.slave  bus
);

    localparam logic [2:0] FILT_M1 = 3'(FILT - 1);

    typedef enum logic [1:0] {ST_INIT, ST_PRIME, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic             init_cnt_q, init_cnt_d;
    logic [1:0]       sync1_q, sync1_d;     // bit 1 = A, bit 0 = B
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       filt_q, filt_d;
    logic [1:0][2:0]  cnt_q, cnt_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             err_q, err_d;
    logic             dir_q, dir_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] pos_q, pos_d;

    logic run_en, prime_en;
    logic fwd, rev, bad;

    // State register plus all datapath flops
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            cnt_q      <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            err_q      <= 1'b0;
            dir_q      <= 1'b1;
            sticky_q   <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            up_q       <= up_d;
            down_q     <= down_d;
            err_q      <= err_d;
            dir_q      <= dir_d;
            sticky_q   <= sticky_d;
            pos_q      <= pos_d;
        end
    end

    // Next state: two INIT cycles let the synchronizer fill, one PRIME cycle
    // seeds the filter, then RUN forever.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = 1'b1;
                if (init_cnt_q) state_d = ST_PRIME;
            end
            ST_PRIME: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        run_en   = (state_q == ST_RUN);
        prime_en = (state_q == ST_PRIME);
    end

    // Synchronizers and per-channel filters
    always_comb begin
        sync1_d = {bus.A, bus.B};
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        if (prime_en) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else if (run_en) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    // Accept on the FILT-th consecutive differing sample
                    if (cnt_q[i] == FILT_M1) begin
                        filt_d[i] = sync2_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i]  = cnt_q[i] + 3'd1;
                    end
                end else begin
                    cnt_d[i] = '0;   // reverted: restart stability count
                end
            end
        end
    end

    // Step decode. Forward successor of {a,b} in 00->01->11->10 is {b,~a};
    // reverse predecessor is {~b,a}. Both bits flipping is illegal.
    always_comb begin
        fwd = run_en && (filt_d == {filt_q[0], ~filt_q[1]});
        rev = run_en && (filt_d == {~filt_q[0], filt_q[1]});
        bad = run_en && ((filt_d ^ filt_q) == 2'b11);

        up_d   = fwd;
        down_d = rev;
        err_d  = bad;

        dir_d = dir_q;
        if (fwd)      dir_d = 1'b1;
        else if (rev) dir_d = 1'b0;

        pos_d = pos_q;
        if (bus.Clr)                       pos_d = '0;
        else if (fwd && (pos_q != '1))     pos_d = pos_q + 1'b1;
        else if (rev && (pos_q != '0))     pos_d = pos_q - 1'b1;

        sticky_d = sticky_q;
        if (bus.Clr)  sticky_d = 1'b0;
        else if (bad) sticky_d = 1'b1;
    end

    assign bus.Up         = up_q;
    assign bus.Down       = down_q;
    assign bus.Err        = err_q;
    assign bus.Dir        = dir_q;
    assign bus.Err_Sticky = sticky_q;
    assign bus.Position   = pos_q;
    assign bus.High       = &pos_q;
    assign bus.Low        = ~|pos_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized self-checking bench for quad_decoder against a step-level model.
module tb_quad_decoder;

    localparam int WIDTH = 5;
    localparam int FILT  = 2;
    localparam int LAT   = FILT + 1;
    localparam int MAXP  = (1 << WIDTH) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    quad_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder #(.WIDTH(WIDTH), .FILT(FILT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: current pin level, position, sticky, direction
    logic [1:0] m_ab;
    int         m_pos;
    bit         m_sticky;
    bit         m_dir;

    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gval(input int i);
        logic [1:0] tbl [4];
        tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
        return tbl[i % 4];
    endfunction

    // Clear (if any) lands on the same edge as the step and wins over it.
    task automatic model_apply(input logic [1:0] nab, input bit clr,
                               output int eu, output int ed, output int ee);
        int d;
        d  = (gidx(nab) - gidx(m_ab) + 4) % 4;
        eu = (d == 1);
        ed = (d == 3);
        ee = (d == 2);
        if (eu != 0) begin m_dir = 1'b1; if (m_pos < MAXP) m_pos++; end
        if (ed != 0) begin m_dir = 1'b0; if (m_pos > 0) m_pos--; end
        if (ee != 0) m_sticky = 1'b1;
        if (clr) begin m_pos = 0; m_sticky = 1'b0; end
        m_ab = nab;
    endtask

    // Drive a level and observe pulses over 'hold' edges; first = edge index
    // (0 = edge that first samples the pin) of the first pulse, -1 if none.
    task automatic apply_level(input logic [1:0] ab, input int hold, input int clr_at,
                               output int nu, output int nd, output int ne, output int first);
        @(negedge CLK);
        bus.A = ab[1];
        bus.B = ab[0];
        nu = 0; nd = 0; ne = 0; first = -1;
        for (int k = 0; k < hold; k++) begin
            bus.Clr = (k == clr_at);
            @(posedge CLK);
            #1;
            if ((bus.Up | bus.Down | bus.Err) && first < 0) first = k;
            nu += int'(bus.Up);
            nd += int'(bus.Down);
            ne += int'(bus.Err);
        end
        bus.Clr = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] ab);
        @(negedge CLK);
        RST = 1'b0; bus.Clr = 1'b0;
        bus.A = ab[1]; bus.B = ab[0];
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        m_ab = ab; m_pos = 0; m_sticky = 1'b0; m_dir = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0; bus.Clr = 1'($urandom);
        bus.A = 1'($urandom); bus.B = 1'($urandom);
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if ({bus.Up, bus.Down, bus.Err, bus.Err_Sticky} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_pulses got %b want 0000", {bus.Up, bus.Down, bus.Err, bus.Err_Sticky});
        end
        n_cmp++;
        if ({bus.Dir, bus.High, bus.Low} !== 3'b101 || bus.Position !== '0) begin
            n_bad++; $display("FAIL reset_state got dir/high/low=%b pos=%0d want 101 pos=0",
                              {bus.Dir, bus.High, bus.Low}, bus.Position);
        end
    endtask

    // Release reset with pins at 11: PRIME loads 11 silently.
    task automatic test_prime();
        int cnt;
        @(negedge CLK);
        RST = 1'b0; bus.Clr = 1'b0; bus.A = 1'b1; bus.B = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            cnt += int'(bus.Up) + int'(bus.Down) + int'(bus.Err);
        end
        n_cmp++;
        if (cnt != 0 || bus.Position !== '0 || bus.Err_Sticky !== 1'b0) begin
            n_bad++; $display("FAIL prime_11 got pulses=%0d pos=%0d sticky=%b want 0 0 0",
                              cnt, bus.Position, bus.Err_Sticky);
        end
        m_ab = 2'b11; m_pos = 0; m_sticky = 1'b0; m_dir = 1'b1;
        // A forward step from 11 proves the primed state was 11
        begin
            int nu, nd, ne, first, eu, ed, ee;
            apply_level(2'b10, 6, -1, nu, nd, ne, first);
            model_apply(2'b10, 1'b0, eu, ed, ee);
            n_cmp++;
            if (nu != eu || nd != ed || ne != ee || first != LAT) begin
                n_bad++; $display("FAIL prime_step got u/d/e=%0d/%0d/%0d at %0d want %0d/%0d/%0d at %0d",
                                  nu, nd, ne, first, eu, ed, ee, LAT);
            end
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [4];
        int nu, nd, ne, first, eu, ed, ee;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        do_reset(2'b00);
        foreach (seq[i]) begin
            apply_level(seq[i], 6, -1, nu, nd, ne, first);
            model_apply(seq[i], 1'b0, eu, ed, ee);
            n_cmp++;
            if (nu != 1 || nd != 0 || ne != 0 || first != LAT) begin
                n_bad++; $display("FAIL fwd_step%0d got u/d/e=%0d/%0d/%0d at %0d want 1/0/0 at %0d",
                                  i, nu, nd, ne, first, LAT);
            end
        end
        n_cmp++;
        if (int'(bus.Position) != 4 || bus.Dir !== 1'b1 || m_pos != 4) begin
            n_bad++; $display("FAIL fwd_final got pos=%0d dir=%b want pos=4 dir=1", bus.Position, bus.Dir);
        end
    endtask

    // Five reverse steps from position 4: down to 0, then a Down held at 0.
    task automatic test_reverse();
        int nu, nd, ne, first, eu, ed, ee;
        int gi;
        gi = gidx(m_ab);
        for (int i = 0; i < 5; i++) begin
            gi = (gi + 3) % 4;
            apply_level(gval(gi), 6, -1, nu, nd, ne, first);
            model_apply(gval(gi), 1'b0, eu, ed, ee);
            n_cmp++;
            if (nd != 1 || nu != 0 || ne != 0 || first != LAT ||
                int'(bus.Position) != m_pos || bus.Dir !== 1'b0) begin
                n_bad++; $display("FAIL rev_step%0d got d=%0d u=%0d e=%0d at %0d pos=%0d dir=%b want 1/0/0 at %0d pos=%0d dir=0",
                                  i, nd, nu, ne, first, bus.Position, bus.Dir, LAT, m_pos);
            end
        end
        n_cmp++;
        if (bus.Low !== 1'b1 || bus.Position !== '0) begin
            n_bad++; $display("FAIL rev_low got low=%b pos=%0d want 1 0", bus.Low, bus.Position);
        end
    endtask

    // One-cycle pulse on a pin must be filtered away.
    task automatic test_glitch();
        int cnt;
        for (int ch = 0; ch < 2; ch++) begin
            @(negedge CLK);
            if (ch == 0) bus.A = ~m_ab[1]; else bus.B = ~m_ab[0];
            @(negedge CLK);
            bus.A = m_ab[1]; bus.B = m_ab[0];
            cnt = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge CLK); #1;
                cnt += int'(bus.Up) + int'(bus.Down) + int'(bus.Err);
            end
            n_cmp++;
            if (cnt != 0 || int'(bus.Position) != m_pos) begin
                n_bad++; $display("FAIL glitch_ch%0d got pulses=%0d pos=%0d want 0 pos=%0d", ch, cnt, bus.Position, m_pos);
            end
        end
        // Filtered state unchanged: a forward step from the old level still counts as forward
        begin
            int nu, nd, ne, first, eu, ed, ee;
            logic [1:0] nx;
            nx = gval(gidx(m_ab) + 1);
            apply_level(nx, 6, -1, nu, nd, ne, first);
            model_apply(nx, 1'b0, eu, ed, ee);
            n_cmp++;
            if (nu != 1 || nd != 0 || ne != 0) begin
                n_bad++; $display("FAIL glitch_state got u/d/e=%0d/%0d/%0d want 1/0/0", nu, nd, ne);
            end
        end
    endtask

    task automatic test_error();
        int nu, nd, ne, first, eu, ed, ee;
        logic [1:0] nx;
        int pos0;
        bit dir0;
        pos0 = m_pos; dir0 = m_dir;
        nx = ~m_ab;
        apply_level(nx, 6, -1, nu, nd, ne, first);
        model_apply(nx, 1'b0, eu, ed, ee);
        n_cmp++;
        if (ne != 1 || nu != 0 || nd != 0 || first != LAT) begin
            n_bad++; $display("FAIL err_pulse got e/u/d=%0d/%0d/%0d at %0d want 1/0/0 at %0d", ne, nu, nd, first, LAT);
        end
        n_cmp++;
        if (bus.Err_Sticky !== 1'b1 || int'(bus.Position) != pos0 || bus.Dir !== dir0) begin
            n_bad++; $display("FAIL err_hold got sticky=%b pos=%0d dir=%b want 1 %0d %b",
                              bus.Err_Sticky, bus.Position, bus.Dir, pos0, dir0);
        end
        // Plain Clr
        apply_level(m_ab, 3, 0, nu, nd, ne, first);
        model_apply(m_ab, 1'b1, eu, ed, ee);
        n_cmp++;
        if (bus.Err_Sticky !== 1'b0 || bus.Position !== '0 || nu + nd + ne != 0) begin
            n_bad++; $display("FAIL err_clr got sticky=%b pos=%0d pulses=%0d want 0 0 0",
                              bus.Err_Sticky, bus.Position, nu + nd + ne);
        end
        // Err coincident with Clr: pulse still issued, sticky ends clear
        nx = ~m_ab;
        apply_level(nx, 6, LAT, nu, nd, ne, first);
        model_apply(nx, 1'b1, eu, ed, ee);
        n_cmp++;
        if (ne != 1 || bus.Err_Sticky !== 1'b0) begin
            n_bad++; $display("FAIL err_with_clr got err=%0d sticky=%b want 1 0", ne, bus.Err_Sticky);
        end
    endtask

    // Clr on the step edge: pulse and Dir still issued, Position ends 0.
    task automatic test_clr_step();
        int nu, nd, ne, first, eu, ed, ee;
        logic [1:0] nx;
        for (int i = 0; i < 3; i++) begin
            nx = gval(gidx(m_ab) + 1);
            apply_level(nx, 6, -1, nu, nd, ne, first);
            model_apply(nx, 1'b0, eu, ed, ee);
        end
        nx = gval(gidx(m_ab) + 3);
        apply_level(nx, 6, LAT, nu, nd, ne, first);
        model_apply(nx, 1'b1, eu, ed, ee);
        n_cmp++;
        if (nd != 1 || first != LAT || bus.Dir !== 1'b0 || bus.Position !== '0) begin
            n_bad++; $display("FAIL clr_step got down=%0d at %0d dir=%b pos=%0d want 1 at %0d dir=0 pos=0",
                              nd, first, bus.Dir, bus.Position, LAT);
        end
    endtask

    task automatic test_saturate();
        int nu, nd, ne, first, eu, ed, ee, ups;
        logic [1:0] nx;
        do_reset(2'b00);
        ups = 0;
        for (int i = 0; i < 35; i++) begin
            nx = gval(gidx(m_ab) + 1);
            apply_level(nx, LAT + 2, -1, nu, nd, ne, first);
            model_apply(nx, 1'b0, eu, ed, ee);
            ups += nu;
        end
        n_cmp++;
        if (ups != 35 || int'(bus.Position) != MAXP || bus.High !== 1'b1 || bus.Low !== 1'b0) begin
            n_bad++; $display("FAIL saturate got ups=%0d pos=%0d high=%b low=%b want 35 %0d 1 0",
                              ups, bus.Position, bus.High, bus.Low, MAXP);
        end
    endtask

    // Reset asserted while a change is in the filter: nothing reported after.
    task automatic test_reset_mid_step();
        int cnt;
        logic [1:0] nx;
        nx = gval(gidx(m_ab) + 1);
        @(negedge CLK);
        bus.A = nx[1]; bus.B = nx[0];
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if ({bus.Up, bus.Down, bus.Err} !== 3'b000 || bus.Position !== '0) begin
            n_bad++; $display("FAIL rst_mid got u/d/e=%b pos=%0d want 000 0", {bus.Up, bus.Down, bus.Err}, bus.Position);
        end
        @(negedge CLK);
        RST = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            cnt += int'(bus.Up) + int'(bus.Down) + int'(bus.Err);
        end
        n_cmp++;
        if (cnt != 0) begin
            n_bad++; $display("FAIL rst_mid_after got pulses=%0d want 0", cnt);
        end
        m_ab = nx; m_pos = 0; m_sticky = 1'b0; m_dir = 1'b1;
    endtask

    task automatic test_random();
        int nu, nd, ne, first, eu, ed, ee, kind, hold, clr_at, efirst;
        logic [1:0] nx;
        do_reset(2'($urandom));
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4)      nx = gval(gidx(m_ab) + 1);
            else if (kind <= 7) nx = gval(gidx(m_ab) + 3);
            else if (kind == 8) nx = ~m_ab;
            else                nx = m_ab;
            hold   = $urandom_range(LAT + 1, LAT + 5);
            clr_at = ($urandom_range(0, 5) == 0) ? LAT : -1;
            apply_level(nx, hold, clr_at, nu, nd, ne, first);
            model_apply(nx, clr_at >= 0, eu, ed, ee);
            efirst = (eu + ed + ee != 0) ? LAT : -1;
            n_cmp++;
            if (nu != eu || nd != ed || ne != ee || first != efirst) begin
                n_bad++; $display("FAIL rnd%0d_pulse got u/d/e=%0d/%0d/%0d at %0d want %0d/%0d/%0d at %0d",
                                  i, nu, nd, ne, first, eu, ed, ee, efirst);
            end
            n_cmp++;
            if (int'(bus.Position) != m_pos || bus.Dir !== m_dir || bus.Err_Sticky !== m_sticky ||
                bus.High !== (m_pos == MAXP) || bus.Low !== (m_pos == 0)) begin
                n_bad++; $display("FAIL rnd%0d_state got pos=%0d dir=%b sticky=%b hi=%b lo=%b want %0d %b %b %b %b",
                                  i, bus.Position, bus.Dir, bus.Err_Sticky, bus.High, bus.Low,
                                  m_pos, m_dir, m_sticky, m_pos == MAXP, m_pos == 0);
            end
        end
    endtask

    initial begin
        bus.A = 1'b0; bus.B = 1'b0; bus.Clr = 1'b0;
        test_reset();
        test_prime();
        test_forward();
        test_reverse();
        test_glitch();
        test_error();
        test_clr_step();
        test_saturate();
        test_reset_mid_step();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
